// File: rtl/alu_mem_unit.sv
// alu_mem_unit: one-shot ALU add / load / store / read-modify-write unit.
// start/ready/done handshake; single-port data RAM addressed by the registered ALU sum.
module alu_mem_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a_val,
    input  logic [DATA_W-1:0] b_val,
    input  logic [DATA_W-1:0] imm,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] mem_out,
    output logic              zero,
    output logic              ovflw
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [1:0] OP_ALU = 2'b00, OP_LOAD = 2'b01, OP_RMW = 2'b11;
    typedef enum logic [2:0] {IDLE, EXEC, MEM, MOD, DONE} state_t;
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0] alu_q, alu_d, mem_out_q, mem_out_d, rdata_q, rdata_d;
    logic              zero_q, zero_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] op2, sum, wdata;
    logic [ADDR_W-1:0] addr;
    logic              we;
    assign op2   = (op_q == OP_ALU) ? b_q : imm_q;
    assign sum   = a_q + op2;
    assign addr  = alu_q[ADDR_W-1:0];
    assign wdata = (state_q == MOD) ? rdata_q + b_q : b_q;
    // Gating on reset drops any write whose edge coincides with reset asserted.
    assign we    = reset && ((state_q == MOD) || (state_q == MEM && op_q == 2'b10));
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        mem_out_d = mem_out_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = EXEC;
                op_d    = op;
                a_d     = a_val;
                b_d     = b_val;
                imm_d   = imm;
            end
            EXEC: begin
                alu_d   = sum;
                zero_d  = (sum == '0);
                ovf_d   = (a_q[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
                state_d = (op_q == OP_ALU) ? DONE : MEM;
            end
            MEM: begin
                if (op_q == OP_RMW) rdata_d = mem[addr];
                else mem_out_d = (op_q == OP_LOAD) ? mem[addr] : b_q;
                state_d = (op_q == OP_RMW) ? MOD : DONE;
            end
            MOD: begin
                mem_out_d = wdata;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mem_out_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            mem_out_q <= mem_out_d;
            rdata_q   <= rdata_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (we) mem[addr] <= wdata;
    end
    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign alu_out = alu_q;
    assign mem_out = mem_out_q;
    assign zero    = zero_q;
    assign ovflw   = ovf_q;
endmodule

// File: tb/tb_alu_mem_unit.sv
// tb_alu_mem_unit: directed vectors with hand-computed expectations for alu_mem_unit.
module tb_alu_mem_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a_val = '0, b_val = '0, imm = '0;
    logic        ready, done, zero, ovflw;
    logic [15:0] alu_out, mem_out;
    int          n_pass = 0, n_total = 0;
    int          lat, dones;

    alu_mem_unit #(.DATA_W(16), .ADDR_W(8)) dut (
        .CLK(clk), .reset(reset), .start(start), .op(op),
        .a_val(a_val), .b_val(b_val), .imm(imm),
        .ready(ready), .done(done), .alu_out(alu_out), .mem_out(mem_out),
        .zero(zero), .ovflw(ovflw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Issue one op, return edges from capture to done; check the one-cycle done pulse.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] im, output int l);
        wait_ready();
        start = 1'b1; op = o; a_val = a; b_val = b; imm = im;
        @(posedge clk); #1;
        start = 1'b0; a_val = '0; b_val = '0; imm = '0;
        l = 0;
        while (!done && l < 10) begin
            @(posedge clk); #1;
            l++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {30'b0, done, ready}, 32'b01);
    endtask

    initial begin
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_alu", {16'b0, alu_out}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", {31'b0, ready}, 32'd1);
        check("rel_done", {31'b0, done}, 32'd0);
        check("rel_alu", {16'b0, alu_out}, 32'h0);
        check("rel_mem", {16'b0, mem_out}, 32'h0);
        check("rel_flags", {30'b0, zero, ovflw}, 32'h0);

        do_op("alu1", 2'b00, 16'h7FFF, 16'h0001, 16'h0000, lat);
        check("alu1_lat", lat, 32'd1);
        check("alu1_out", {16'b0, alu_out}, 32'h8000);
        check("alu1_flags", {30'b0, zero, ovflw}, 32'b01);
        check("alu1_mem", {16'b0, mem_out}, 32'h0);

        do_op("alu2", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, lat);
        check("alu2_out", {16'b0, alu_out}, 32'h0000);
        check("alu2_flags", {30'b0, zero, ovflw}, 32'b10);

        do_op("st1", 2'b10, 16'h1232, 16'h8888, 16'h0002, lat);
        check("st1_lat", lat, 32'd2);
        check("st1_alu", {16'b0, alu_out}, 32'h1234);
        check("st1_mem", {16'b0, mem_out}, 32'h8888);

        do_op("ld1", 2'b01, 16'h0030, 16'h0000, 16'h0004, lat);
        check("ld1_lat", lat, 32'd2);
        check("ld1_mem", {16'b0, mem_out}, 32'h8888);

        do_op("rmw1", 2'b11, 16'h0034, 16'h0001, 16'h0000, lat);
        check("rmw1_lat", lat, 32'd3);
        check("rmw1_mem", {16'b0, mem_out}, 32'h8889);

        do_op("ld2", 2'b01, 16'h0034, 16'h0000, 16'h0000, lat);
        check("ld2_mem", {16'b0, mem_out}, 32'h8889);

        do_op("st_wrap", 2'b10, 16'h00FF, 16'h1111, 16'h0001, lat);
        check("st_wrap_alu", {16'b0, alu_out}, 32'h0100);
        check("st_wrap_zero", {31'b0, zero}, 32'd0);
        do_op("ld_wrap", 2'b01, 16'h0000, 16'h0000, 16'h0000, lat);
        check("ld_wrap_mem", {16'b0, mem_out}, 32'h1111);

        // start pulsed mid-RMW must be ignored
        wait_ready();
        start = 1'b1; op = 2'b11; a_val = 16'h0034; b_val = 16'h0000; imm = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a_val = 16'h0034; b_val = 16'hDEAD; imm = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("busy_dones", dones, 32'd1);
        check("busy_mem", {16'b0, mem_out}, 32'h8889);
        do_op("busy_ld", 2'b01, 16'h0034, 16'h0000, 16'h0000, lat);
        check("busy_ld_mem", {16'b0, mem_out}, 32'h8889);

        // reset during MOD drops the pending write
        wait_ready();
        start = 1'b1; op = 2'b11; a_val = 16'h0034; b_val = 16'h0001; imm = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        check("mid_rst_alu", {16'b0, alu_out}, 32'h0);
        check("mid_rst_mem", {16'b0, mem_out}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'b0, ready}, 32'd1);
        check("post_rst_done", {31'b0, done}, 32'd0);
        do_op("post_ld", 2'b01, 16'h0034, 16'h0000, 16'h0000, lat);
        check("post_ld_mem", {16'b0, mem_out}, 32'h8889);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_mem_unit.md
Name: alu_mem_unit

Overview:
- Parametrised successor of the stack processor's ALU / ALUOut / data-memory slice.
- Runs one operation per start request: register-only ALU add, load, store, or read-modify-write (RMW) at address a_val+imm.
- Handshake is start/ready/done, with a small FSM sequencing ALU, address and memory phases.
- Sits between the stack datapath and the data RAM; the control unit drives it.

Parameters:
- DATA_W, 16, datapath and memory word width.
- ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W words.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the FSM and all output registers to reset values immediately.
- start  in  1  request; sampled only when ready=1.
- op  in  2  00 ALU_ONLY, 01 LOAD, 10 STORE, 11 RMW.
- a_val  in  DATA_W  A operand / base address.
- b_val  in  DATA_W  B operand / store data / RMW addend.
- imm  in  DATA_W  sign-extended immediate offset.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse at operation completion.
- alu_out  out  DATA_W  registered ALU result (ALUOut).
- mem_out  out  DATA_W  registered memory result.
- zero  out  1  alu_out == 0, registered with alu_out.
- ovflw  out  1  signed overflow of the ALU add, registered with alu_out.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, ready=1, done=0, alu_out=0, mem_out=0, zero=0, ovflw=0.
  - Memory array is NOT cleared; contents persist across reset.
- States: IDLE, EXEC, MEM, MOD, DONE.
- Edge E0, IDLE with start=1: capture op, a_val, b_val, imm into internal registers; go to EXEC. Inputs may change afterwards.
- Edge E1, EXEC:
  - ALU operand 2 is b for ALU_ONLY, imm for all other ops.
  - alu_out <= a + operand2, truncated to DATA_W; latch zero and ovflw.
  - ovflw = operand signs equal and result sign differs.
  - ALU_ONLY goes to DONE; other ops go to MEM.
- Address: addr = alu_out[ADDR_W-1:0]. Higher bits are discarded, so addresses wrap modulo DEPTH.
- Edge E2, MEM:
  - LOAD: mem_out <= mem[addr]; go to DONE.
  - STORE: mem[addr] <= b and mem_out <= b (write-through); go to DONE.
  - RMW: capture rdata <= mem[addr]; go to MOD.
- Edge E3, MOD (RMW only):
  - mem[addr] <= rdata + b and mem_out <= rdata + b, both truncated.
  - Data overflow is not flagged; ovflw keeps its E1 value.
  - Go to DONE.
- DONE: done=1, ready=0 for exactly one cycle, then IDLE.
- Latency, counted as edges from the start-capture edge to the cycle done is high: ALU_ONLY 1, LOAD/STORE 2, RMW 3. ready returns the cycle after done.
- ALU_ONLY leaves mem_out unchanged. LOAD/STORE/RMW update alu_out, zero and ovflw with the address sum.
- start while not IDLE is ignored; no queueing.
- start held high through DONE is taken at the first IDLE edge; back-to-back operations therefore have one idle cycle between them.
- Reset asserted mid-operation:
  - Any memory write not yet performed at an edge is dropped.
  - A write completed on an earlier edge stays.
  - A write is performed at E2/E3 only if reset=1 at that edge.
- Memory uses a synchronous read with a single port. Reads and writes never occur in the same cycle.

Test Plan (DATA_W=16, ADDR_W=8):
- Reset held low, then released -> ready=1, done=0, alu_out=0000, mem_out=0000, zero=0, ovflw=0.
- ALU_ONLY a=7FFF b=0001 -> done 1 edge after capture; alu_out=8000, ovflw=1, zero=0, mem_out unchanged.
- ALU_ONLY a=FFFF b=0001 -> alu_out=0000, zero=1, ovflw=0.
- STORE a=1232 imm=0002 b=8888 -> alu_out=1234, addr 34; mem_out=8888, done 2 edges after capture. Then LOAD a=0030 imm=0004 -> mem_out=8888.
- RMW a=0034 imm=0000 b=0001 (mem[34]=8888) -> done 3 edges after capture; mem_out=8889. LOAD a=0034 -> 8889. Wrap case: STORE a=00FF imm=0001 b=1111, then LOAD a=0000 -> 1111.
- Robustness, part 1: pulse start with op=STORE while an RMW is busy -> ignored, only one done.
- Robustness, part 2: start RMW at 34 with b=0001, assert reset during MOD -> outputs clear immediately. A following LOAD at 34 returns 8889 (no write), and ready=1 after release.
